seq_lock_ctrl: RTL and testbench
================================

# seq_lock_ctrl

Switch-sequence lock controller for the board-level lab designs. It debounces the four slide switches and turns each newly settled non-zero switch code into a single token. It steps a 4-code unlock sequence (0001, 0010, 0100, 1000), enforces an inter-step timeout and counts failed attempts. It drives the two status LEDs plus unlock, fail and lockout indications, replacing ad-hoc raw-switch sequence FSMs.

## Interface
Parameters:
- DB_CYCLES, 4: consecutive equal samples required before a switch code is accepted (≥2).
- TIMEOUT_CYCLES, 1000: edges allowed between tokens once a sequence has started (≥2).
- MAX_FAILS, 3: failed attempts that trigger lockout (≥1).
- LOCKOUT_CYCLES, 5000: lockout duration in edges (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high; clears all state at the next rising edge of clk.
- sw30  in  4  raw switch inputs, asynchronous to clk, bouncing.
- led  out  2  progress code: 00 IDLE, 01 GOT1, 10 GOT2, 11 GOT3; 00 during LOCKOUT.
- unlock  out  1  one-cycle pulse on sequence completion.
- fail  out  1  one-cycle pulse on wrong code or timeout.
- locked  out  1  level, high while in LOCKOUT.

## Operation
- Reset values: led=00, unlock=0, fail=0, locked=0, state=IDLE, fail_cnt=0, cand=0000, stable=0000, db_cnt=0, timers=0.
- Debounce, each edge:
  - sw30≠cand: cand<=sw30, db_cnt<=1.
  - otherwise: db_cnt increments, saturating at DB_CYCLES.
- Token: tok_valid=(db_cnt==DB_CYCLES)&&(cand≠stable); stable<=cand on that edge. Token consumed only if cand≠0000; settling to 0000 updates stable and produces no token.
- Same code twice needs an intervening different settled value (normally 0000).
- Expected code per state: IDLE→0001, GOT1→0010, GOT2→0100, GOT3→1000.
- Matching token: advance one state. In GOT3: unlock pulse, go to IDLE, fail_cnt<=0.
- Non-matching token, including non-one-hot codes, in any of IDLE/GOT1/GOT2/GOT3: fail pulse, fail_cnt+1, go to IDLE.
- Timeout: tmr clears on any token and on entering IDLE, and counts in GOT1..GOT3. When tmr==TIMEOUT_CYCLES-1 with no token, treat as failure: same response as a wrong code.
- Token and timeout on the same edge: the token wins.
- fail_cnt saturates at MAX_FAILS.
- Reset mid-sequence or mid-lockout: return to reset values with no unlock/fail pulse emitted.

## Timing
- sw30 changes before edge E and then holds: cand loads at E; stable, state, led, unlock and fail update at edge E+DB_CYCLES-1.
- Any sw30 change before then restarts the count.
- Outputs are registered: unlock and fail are high for exactly one cycle after the deciding edge.
- Timeout: the failure edge is the TIMEOUT_CYCLES-th edge after the last accepted token.
- Lockout: LOCKOUT_CYCLES edges from entry, then IDLE with fail_cnt=0 and locked=0 on the same edge.

## Configuration
- Macro: SEQ_LOCK_LOCKOUT_EN.
- Defined:
  - The failure that brings fail_cnt to MAX_FAILS enters LOCKOUT instead of IDLE. fail still pulses, and locked rises on the same edge.
  - In LOCKOUT, tokens are discarded (the debouncer keeps tracking stable) and timeouts cannot occur.
- Undefined: no LOCKOUT state; locked is tied 0; fail_cnt still saturates and only clears on unlock or rst.

## Test plan
Bench parameters: DB_CYCLES=4, TIMEOUT_CYCLES=20, MAX_FAILS=3, LOCKOUT_CYCLES=50, macro defined.
- Clean sequence: 0001,0000,0010,0000,0100,0000,1000, each held 10 cycles -> led 01,01,10,10,11,11 then 00; one unlock pulse 3 edges after 1000 is applied; fail never high.
- Bounce: sw30 toggles 0000/0001 every cycle for 8 cycles, then holds 0001 -> no token during bouncing; led=01 exactly 3 edges after the final hold begins.
- Wrong code: after reaching GOT2 apply 1000 -> one fail pulse, led=00, fail_cnt=1.
- Timeout: reach GOT1, then hold 0000 for 25 cycles -> fail pulse at edge 20 after the accepted token; led=00.
- Lockout: three consecutive wrong tokens (0011) -> locked=1 on the third fail edge; a correct 0001 during lockout leaves led=00; locked=0 after 50 edges; a full sequence afterwards unlocks.
- Reset mid-sequence: assert rst for 1 cycle while in GOT3 -> led=00, no unlock or fail pulse, fail_cnt=0.

Source files
------------

// File: rtl/seq_lock_ctrl_if.sv
// seq_lock_ctrl_if: raw switch input and status outputs of the switch-sequence lock.
// The master side drives the switches and watches the status; the slave side is the lock.
interface seq_lock_ctrl_if;
    logic [3:0] sw30;
    logic [1:0] led;
    logic       unlock;
    logic       fail;
    logic       locked;

    modport master (
        output sw30,
        input  led,
        input  unlock,
        input  fail,
        input  locked
    );

    modport slave (
        input  sw30,
        output led,
        output unlock,
        output fail,
        output locked
    );
endinterface

// File: rtl/seq_lock_ctrl.sv
// seq_lock_ctrl: switch-sequence lock controller.
// Debounces the four slide switches, turns every newly settled non-zero code into one
// token, and walks the unlock sequence 0001 -> 0010 -> 0100 -> 1000 with an inter-token
// timeout and a saturating failed-attempt counter.
// Optional feature macro: SEQ_LOCK_LOCKOUT_EN -- when defined, reaching MAX_FAILS failures
// enters a LOCKOUT state for LOCKOUT_CYCLES edges during which tokens are ignored.
module seq_lock_ctrl #(
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic           clk,
    input  logic           rst,
    seq_lock_ctrl_if.slave bus
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FC_W    = $clog2(MAX_FAILS + 1);

    localparam logic [DB_W-1:0]  DB_SAT   = DB_W'(DB_CYCLES);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_SAT   = FC_W'(MAX_FAILS);
`ifdef SEQ_LOCK_LOCKOUT_EN
    localparam logic [TMR_W-1:0] LCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAILS - 1);
`endif

    // Encoding of the progress states equals the led code and the index of the
    // one-hot switch expected next.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GOT1    = 3'd1,
        ST_GOT2    = 3'd2,
        ST_GOT3    = 3'd3
`ifdef SEQ_LOCK_LOCKOUT_EN
        , ST_LOCKOUT = 3'd4
`endif
    } state_t;

    // Debouncer state
    logic [3:0]       cand_reg, cand_next;
    logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
    logic [3:0]       stable_reg, stable_next;
    logic             tok_valid;
    logic             tok_use;

    // Sequencer state
    state_t           state_reg, state_next;
    logic [FC_W-1:0]  fail_cnt_reg, fail_cnt_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             unlock_reg, unlock_next;
    logic             fail_reg, fail_next;
    logic [3:0]       exp_code;

    // Debounce: restart the count on any change, otherwise count up and saturate.
    // cand_reg is the capture register for the asynchronous switches; a token only
    // forms after DB_CYCLES agreeing samples, so a single unsettled sample is harmless.
    always_comb begin
        if (bus.sw30 != cand_reg) begin
            cand_next   = bus.sw30;
            db_cnt_next = DB_W'(1);
        end else begin
            cand_next   = cand_reg;
            db_cnt_next = (db_cnt_reg == DB_SAT) ? db_cnt_reg : db_cnt_reg + DB_W'(1);
        end
        tok_valid   = (db_cnt_next == DB_SAT) && (cand_next != stable_reg);
        stable_next = tok_valid ? cand_reg : stable_reg;
        // Settling back to all-off refreshes stable_reg but is not a token.
        tok_use     = tok_valid && (cand_reg != 4'b0000);
    end

    // Debouncer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_reg   <= 4'b0000;
            db_cnt_reg <= '0;
            stable_reg <= 4'b0000;
        end else begin
            cand_reg   <= cand_next;
            db_cnt_reg <= db_cnt_next;
            stable_reg <= stable_next;
        end
    end

    // Expected one-hot code: bit gi is wanted while in the gi-th progress state.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_exp
            assign exp_code[gi] = (state_reg == 3'(gi));
        end
    endgenerate

    // FSM state register, including the shared timer and the registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fail_cnt_reg <= '0;
            tmr_reg      <= '0;
            unlock_reg   <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fail_cnt_reg <= fail_cnt_next;
            tmr_reg      <= tmr_next;
            unlock_reg   <= unlock_next;
            fail_reg     <= fail_next;
        end
    end

    // FSM next state: tokens beat a coincident timeout; the timer is zero unless counting.
    always_comb begin
        state_next    = state_reg;
        fail_cnt_next = fail_cnt_reg;
        tmr_next      = '0;
        unlock_next   = 1'b0;
        fail_next     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_GOT1, ST_GOT2, ST_GOT3: begin
                if (tok_use) begin
                    if (cand_reg == exp_code) begin
                        if (state_reg == ST_GOT3) begin
                            unlock_next   = 1'b1;
                            state_next    = ST_IDLE;
                            fail_cnt_next = '0;
                        end else begin
                            state_next = state_t'(state_reg + 3'd1);
                        end
                    end else begin
                        fail_next = 1'b1;
                    end
                end else if (state_reg != ST_IDLE) begin
                    if (tmr_reg == TMO_LAST) begin
                        fail_next = 1'b1;
                    end else begin
                        tmr_next = tmr_reg + TMR_W'(1);
                    end
                end
                if (fail_next) begin
                    state_next = ST_IDLE;
                    if (fail_cnt_reg != FC_SAT) begin
                        fail_cnt_next = fail_cnt_reg + FC_W'(1);
                    end
`ifdef SEQ_LOCK_LOCKOUT_EN
                    if (fail_cnt_reg == FC_LAST) begin
                        state_next = ST_LOCKOUT;
                    end
`endif
                end
            end
`ifdef SEQ_LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                // Tokens are dropped here; only the lockout timer matters.
                if (tmr_reg == LCK_LAST) begin
                    state_next    = ST_IDLE;
                    fail_cnt_next = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: progress code and lock level from the state, pulses from registers.
    always_comb begin
        bus.led    = 2'b00;
        bus.locked = 1'b0;
        case (state_reg)
            ST_GOT1:    bus.led = 2'b01;
            ST_GOT2:    bus.led = 2'b10;
            ST_GOT3:    bus.led = 2'b11;
`ifdef SEQ_LOCK_LOCKOUT_EN
            ST_LOCKOUT: bus.locked = 1'b1;
`endif
            default:    bus.led = 2'b00;
        endcase
        bus.unlock = unlock_reg;
        bus.fail   = fail_reg;
    end

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// tb_seq_lock_ctrl: directed bench for seq_lock_ctrl with DB_CYCLES=4, TIMEOUT_CYCLES=20,
// MAX_FAILS=3, LOCKOUT_CYCLES=50. Lockout checks follow SEQ_LOCK_LOCKOUT_EN.
module tb_seq_lock_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_lock_ctrl_if bus ();

    seq_lock_ctrl #(
        .DB_CYCLES      (4),
        .TIMEOUT_CYCLES (20),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Edge counter: after the N-th rising edge cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and level monitor, sampled on the falling edge.
    int   unlock_cnt      = 0;
    int   fail_seen       = 0;
    int   last_unlock_cyc = -1;
    int   last_fail_cyc   = -1;
    int   lock_rise_cyc   = -1;
    int   lock_fall_cyc   = -1;
    logic prev_locked     = 1'b0;

    always @(negedge clk) begin
        if (bus.unlock === 1'b1) begin
            unlock_cnt++;
            last_unlock_cyc = cyc;
        end
        if (bus.fail === 1'b1) begin
            fail_seen++;
            last_fail_cyc = cyc;
        end
        if (bus.locked === 1'b1 && prev_locked === 1'b0) lock_rise_cyc = cyc;
        if (bus.locked === 1'b0 && prev_locked === 1'b1) lock_fall_cyc = cyc;
        prev_locked = bus.locked;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        bus.sw30 = code;
        repeat (n) step();
        $display("cyc %0d: held sw30=%b for %0d cycles -> led=%b locked=%b", cyc, code, n, bus.led, bus.locked);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        bus.sw30 = 4'b0000;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.sw30 = 4'b0000;
        repeat (2) step();
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL reset_led got=%b exp=00", bus.led); end
        vectors++; if (bus.unlock !== 1'b0) begin miscompares++; $display("FAIL reset_unlock got=%b exp=0", bus.unlock); end
        vectors++; if (bus.fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail got=%b exp=0", bus.fail); end
        vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        vectors++; if (dut.fail_cnt_reg !== 2'd0) begin miscompares++; $display("FAIL reset_fail_cnt got=%0d exp=0", dut.fail_cnt_reg); end
        rst = 1'b0;
        repeat (5) step();
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL post_reset_led got=%b exp=00", bus.led); end
        vectors++; if (fail_seen !== 0) begin miscompares++; $display("FAIL post_reset_fail got=%0d exp=0", fail_seen); end
        $display("cyc %0d: reset test done", cyc);
    endtask

    task automatic test_clean_sequence();
        logic [3:0] codes [0:6];
        logic [1:0] leds  [0:6];
        int u0, f0, n0;
        codes = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        leds  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
        n0 = 0;
        apply_reset();
        u0 = unlock_cnt;
        f0 = fail_seen;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) n0 = cyc;
            hold(codes[i], 10);
            vectors++;
            if (bus.led !== leds[i]) begin
                miscompares++;
                $display("FAIL clean_led step=%0d got=%b exp=%b", i, bus.led, leds[i]);
            end
        end
        vectors++; if (unlock_cnt - u0 !== 1) begin miscompares++; $display("FAIL clean_unlock_count got=%0d exp=1", unlock_cnt - u0); end
        vectors++; if (last_unlock_cyc !== n0 + 4) begin miscompares++; $display("FAIL clean_unlock_edge got=%0d exp=%0d", last_unlock_cyc, n0 + 4); end
        vectors++; if (fail_seen - f0 !== 0) begin miscompares++; $display("FAIL clean_no_fail got=%0d exp=0", fail_seen - f0); end
    endtask

    task automatic test_bounce();
        int f0;
        apply_reset();
        f0 = fail_seen;
        for (int i = 0; i < 8; i++) begin
            bus.sw30 = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step();
            vectors++;
            if (bus.led !== 2'b00) begin
                miscompares++;
                $display("FAIL bounce_led cycle=%0d got=%b exp=00", i, bus.led);
            end
        end
        bus.sw30 = 4'b0001;
        repeat (3) step();
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL bounce_early got=%b exp=00", bus.led); end
        step();
        vectors++; if (bus.led !== 2'b01) begin miscompares++; $display("FAIL bounce_settled got=%b exp=01", bus.led); end
        vectors++; if (fail_seen - f0 !== 0) begin miscompares++; $display("FAIL bounce_no_fail got=%0d exp=0", fail_seen - f0); end
        $display("cyc %0d: bounce settled led=%b", cyc, bus.led);
    endtask

    task automatic test_wrong_code();
        int u0, f0, n0;
        apply_reset();
        hold(4'b0001, 6);
        hold(4'b0000, 6);
        hold(4'b0010, 6);
        vectors++; if (bus.led !== 2'b10) begin miscompares++; $display("FAIL wrong_got2 got=%b exp=10", bus.led); end
        u0 = unlock_cnt;
        f0 = fail_seen;
        n0 = cyc;
        hold(4'b1000, 6);
        vectors++; if (fail_seen - f0 !== 1) begin miscompares++; $display("FAIL wrong_fail_count got=%0d exp=1", fail_seen - f0); end
        vectors++; if (last_fail_cyc !== n0 + 4) begin miscompares++; $display("FAIL wrong_fail_edge got=%0d exp=%0d", last_fail_cyc, n0 + 4); end
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL wrong_led got=%b exp=00", bus.led); end
        vectors++; if (dut.fail_cnt_reg !== 2'd1) begin miscompares++; $display("FAIL wrong_fail_cnt got=%0d exp=1", dut.fail_cnt_reg); end
        vectors++; if (unlock_cnt - u0 !== 0) begin miscompares++; $display("FAIL wrong_no_unlock got=%0d exp=0", unlock_cnt - u0); end
    endtask

    task automatic test_timeout();
        int f0, n0;
        apply_reset();
        f0 = fail_seen;
        n0 = cyc;
        hold(4'b0001, 6);
        vectors++; if (bus.led !== 2'b01) begin miscompares++; $display("FAIL timeout_got1 got=%b exp=01", bus.led); end
        hold(4'b0000, 17);
        vectors++; if (bus.led !== 2'b01) begin miscompares++; $display("FAIL timeout_before_edge got=%b exp=01", bus.led); end
        hold(4'b0000, 8);
        vectors++; if (fail_seen - f0 !== 1) begin miscompares++; $display("FAIL timeout_fail_count got=%0d exp=1", fail_seen - f0); end
        vectors++; if (last_fail_cyc !== n0 + 24) begin miscompares++; $display("FAIL timeout_fail_edge got=%0d exp=%0d", last_fail_cyc, n0 + 24); end
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL timeout_led got=%b exp=00", bus.led); end
        vectors++; if (dut.fail_cnt_reg !== 2'd1) begin miscompares++; $display("FAIL timeout_fail_cnt got=%0d exp=1", dut.fail_cnt_reg); end
    endtask

    task automatic test_lockout();
        logic [3:0] codes [0:6];
        int u0, f0, n2;
        codes = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        n2 = 0;
        apply_reset();
        f0 = fail_seen;
        lock_rise_cyc = -1;
        lock_fall_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            n2 = cyc;
            hold(4'b0011, 6);
            hold(4'b0000, 6);
        end
        vectors++; if (fail_seen - f0 !== 3) begin miscompares++; $display("FAIL lock_fail_count got=%0d exp=3", fail_seen - f0); end
        vectors++; if (last_fail_cyc !== n2 + 4) begin miscompares++; $display("FAIL lock_third_fail_edge got=%0d exp=%0d", last_fail_cyc, n2 + 4); end
`ifdef SEQ_LOCK_LOCKOUT_EN
        vectors++; if (lock_rise_cyc !== n2 + 4) begin miscompares++; $display("FAIL lock_rise_edge got=%0d exp=%0d", lock_rise_cyc, n2 + 4); end
        vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL lock_level got=%b exp=1", bus.locked); end
        u0 = unlock_cnt;
        hold(4'b0001, 10);
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL lock_token_ignored got=%b exp=00", bus.led); end
        vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL lock_still_locked got=%b exp=1", bus.locked); end
        hold(4'b0000, 40);
        vectors++; if (lock_fall_cyc !== n2 + 54) begin miscompares++; $display("FAIL lock_fall_edge got=%0d exp=%0d", lock_fall_cyc, n2 + 54); end
        vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL lock_released got=%b exp=0", bus.locked); end
        vectors++; if (dut.fail_cnt_reg !== 2'd0) begin miscompares++; $display("FAIL lock_fail_cnt_clear got=%0d exp=0", dut.fail_cnt_reg); end
`else
        vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL nolock_level got=%b exp=0", bus.locked); end
        vectors++; if (dut.fail_cnt_reg !== 2'd3) begin miscompares++; $display("FAIL nolock_fail_cnt got=%0d exp=3", dut.fail_cnt_reg); end
        hold(4'b0011, 6);
        hold(4'b0000, 6);
        vectors++; if (dut.fail_cnt_reg !== 2'd3) begin miscompares++; $display("FAIL nolock_fail_cnt_sat got=%0d exp=3", dut.fail_cnt_reg); end
        u0 = unlock_cnt;
`endif
        for (int i = 0; i < 7; i++) hold(codes[i], 6);
        vectors++; if (unlock_cnt - u0 !== 1) begin miscompares++; $display("FAIL lock_after_unlock got=%0d exp=1", unlock_cnt - u0); end
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL lock_after_led got=%b exp=00", bus.led); end
        vectors++; if (dut.fail_cnt_reg !== 2'd0) begin miscompares++; $display("FAIL lock_after_fail_cnt got=%0d exp=0", dut.fail_cnt_reg); end
    endtask

    task automatic test_reset_mid();
        int u0, f0;
        apply_reset();
        hold(4'b0011, 6);
        hold(4'b0000, 6);
        vectors++; if (dut.fail_cnt_reg !== 2'd1) begin miscompares++; $display("FAIL rstmid_pre_fail_cnt got=%0d exp=1", dut.fail_cnt_reg); end
        hold(4'b0001, 6);
        hold(4'b0000, 6);
        hold(4'b0010, 6);
        hold(4'b0000, 6);
        hold(4'b0100, 6);
        vectors++; if (bus.led !== 2'b11) begin miscompares++; $display("FAIL rstmid_got3 got=%b exp=11", bus.led); end
        u0       = unlock_cnt;
        f0       = fail_seen;
        rst      = 1'b1;
        bus.sw30 = 4'b0000;
        step();
        rst = 1'b0;
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL rstmid_led got=%b exp=00", bus.led); end
        vectors++; if (dut.fail_cnt_reg !== 2'd0) begin miscompares++; $display("FAIL rstmid_fail_cnt got=%0d exp=0", dut.fail_cnt_reg); end
        hold(4'b0000, 30);
        vectors++; if (unlock_cnt - u0 !== 0) begin miscompares++; $display("FAIL rstmid_no_unlock got=%0d exp=0", unlock_cnt - u0); end
        vectors++; if (fail_seen - f0 !== 0) begin miscompares++; $display("FAIL rstmid_no_fail got=%0d exp=0", fail_seen - f0); end
        vectors++; if (bus.led !== 2'b00) begin miscompares++; $display("FAIL rstmid_led_idle got=%b exp=00", bus.led); end
    endtask

    initial begin
        rst      = 1'b1;
        bus.sw30 = 4'b0000;
        test_reset();
        test_clean_sequence();
        test_bounce();
        test_wrong_code();
        test_timeout();
        test_lockout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
